// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe move controller: cell and winner codes,
// FSM states and small board helpers.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Square numbers are 1-based; anything outside 1..9 reads as empty.
    function automatic logic [1:0] cell_at(input logic [17:0] brd, input logic [3:0] pos);
        logic [1:0] code;
        code = CELL_EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (pos == 4'(i + 1)) begin
                code = brd[2*i +: 2];
            end
        end
        return code;
    endfunction

    function automatic logic board_full(input logic [17:0] brd);
        logic full;
        full = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (brd[2*i +: 2] == CELL_EMPTY) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/ttt_line_rom.sv
// Combinational table of the eight winning lines: line index -> three 1-based
// square numbers.
module ttt_line_rom
    import ttt_pkg::*;
(
    input  logic [2:0] line_idx,
    output logic [3:0] cell_a,
    output logic [3:0] cell_b,
    output logic [3:0] cell_c
);

    always_comb begin
        cell_a = 4'd1;
        cell_b = 4'd2;
        cell_c = 4'd3;
        case (line_idx)
            3'd0: begin cell_a = 4'd1; cell_b = 4'd2; cell_c = 4'd3; end
            3'd1: begin cell_a = 4'd4; cell_b = 4'd5; cell_c = 4'd6; end
            3'd2: begin cell_a = 4'd7; cell_b = 4'd8; cell_c = 4'd9; end
            3'd3: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
            3'd4: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
            3'd5: begin cell_a = 4'd3; cell_b = 4'd6; cell_c = 4'd9; end
            3'd6: begin cell_a = 4'd1; cell_b = 4'd5; cell_c = 4'd9; end
            3'd7: begin cell_a = 4'd3; cell_b = 4'd5; cell_c = 4'd7; end
            default: begin cell_a = 4'd1; cell_b = 4'd2; cell_c = 4'd3; end
        endcase
    end

endmodule

// File: rtl/move_controller.sv
// Turn sequencer and judge: validates a selected square, strobes the mover's
// board write enable, then scans the eight lines for a win or a draw.
module move_controller
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic [17:0] board,
    output logic [8:0]  P1_en,
    output logic [8:0]  P2_en,
    output logic        ill_move,
    output logic        turn,
    output logic        busy,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t      state, state_next;
    logic [3:0]  move_reg, move_next;
    logic [2:0]  line_idx, idx_next;
    logic        turn_next;
    logic [1:0]  winner_next;
    logic [8:0]  p1_next, p2_next;
    logic        ill_next;
    logic        busy_next;
    logic        over_next;

    logic [3:0]  cell_a, cell_b, cell_c;
    logic [1:0]  mover_code;
    logic        legal;
    logic        line_match;

    ttt_line_rom u_line_rom (
        .line_idx (line_idx),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_c   (cell_c)
    );

    assign mover_code = turn ? CELL_P2 : CELL_P1;

    assign legal = (move_reg != 4'd0) && (move_reg <= 4'd9) &&
                   (cell_at(board, move_reg) == CELL_EMPTY);

    assign line_match = (cell_at(board, cell_a) == mover_code) &&
                        (cell_at(board, cell_b) == mover_code) &&
                        (cell_at(board, cell_c) == mover_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            move_reg  <= 4'd0;
            line_idx  <= 3'd0;
            turn      <= FIRST_PLAYER;
            P1_en     <= 9'd0;
            P2_en     <= 9'd0;
            ill_move  <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            state     <= state_next;
            move_reg  <= move_next;
            line_idx  <= idx_next;
            turn      <= turn_next;
            P1_en     <= p1_next;
            P2_en     <= p2_next;
            ill_move  <= ill_next;
            busy      <= busy_next;
            game_over <= over_next;
            winner    <= winner_next;
        end
    end

    // Strobes and ill_move default low so every pulse lasts exactly one cycle.
    always_comb begin
        state_next  = state;
        move_next   = move_reg;
        idx_next    = line_idx;
        turn_next   = turn;
        winner_next = winner;
        p1_next     = 9'd0;
        p2_next     = 9'd0;
        ill_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (move_valid) begin
                    move_next  = move_pos;
                    state_next = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (!legal) begin
                    ill_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    if (turn) begin
                        p2_next = 9'd1 << (move_reg - 4'd1);
                    end else begin
                        p1_next = 9'd1 << (move_reg - 4'd1);
                    end
                    state_next = ST_WRITE;
                end
            end

            ST_WRITE: begin
                idx_next   = 3'd0;
                state_next = ST_SCAN;
            end

            // Only the player who just moved can have completed a line.
            ST_SCAN: begin
                if (line_match) begin
                    winner_next = turn ? WIN_P2 : WIN_P1;
                    state_next  = ST_DONE;
                end else if (line_idx == 3'(NUM_LINES - 1)) begin
                    if (board_full(board)) begin
                        winner_next = WIN_DRAW;
                        state_next  = ST_DONE;
                    end else begin
                        turn_next  = ~turn;
                        state_next = ST_IDLE;
                    end
                end else begin
                    idx_next = line_idx + 3'd1;
                end
            end

            ST_DONE: begin
                state_next = ST_DONE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_CHECK) || (state_next == ST_WRITE) ||
                    (state_next == ST_SCAN);
        over_next = (state_next == ST_DONE);
    end

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed games plus random games checked against
// a square-array reference model of the rules.
module tb_move_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        move_valid = 1'b0;
    logic [3:0]  move_pos = 4'd0;
    logic [17:0] board;
    logic [8:0]  P1_en, P2_en;
    logic        ill_move, turn, busy, game_over;
    logic [1:0]  winner;

    int total = 0;
    int bad = 0;

    int cells [1:9];
    int m_turn, m_over, m_winner;
    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    move_controller #(.FIRST_PLAYER(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .board      (board),
        .P1_en      (P1_en),
        .P2_en      (P2_en),
        .ill_move   (ill_move),
        .turn       (turn),
        .busy       (busy),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    // Board register file sharing the controller's reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            board <= 18'd0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (P1_en[k]) board[2*k +: 2] <= 2'b01;
                if (P2_en[k]) board[2*k +: 2] <= 2'b10;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 9; i++) cells[i] = 0;
        m_turn = 0;
        m_over = 0;
        m_winner = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_turn"}, 32'(turn), 32'(m_turn));
        chk({tag, "_winner"}, 32'(winner), 32'(m_winner));
        chk({tag, "_over"}, 32'(game_over), 32'(m_over));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One complete selection; returns after the controller has settled.
    task automatic do_move(input int p);
        int legal, was_over, mover, win_line, exp_done, done_k, full;
        logic [8:0] exp1, exp2;
        was_over = m_over;
        mover = m_turn;
        legal = 0;
        if (!m_over && p >= 1 && p <= 9) legal = (cells[p] == 0);
        exp1 = 9'd0;
        exp2 = 9'd0;
        win_line = -1;
        if (legal) begin
            if (mover == 0) exp1 = 9'd1 << (p - 1);
            else exp2 = 9'd1 << (p - 1);
            cells[p] = mover + 1;
            for (int l = 0; l < 8; l++) begin
                if (win_line < 0 && cells[lines[l][0]] == mover + 1 &&
                    cells[lines[l][1]] == mover + 1 && cells[lines[l][2]] == mover + 1)
                    win_line = l;
            end
            full = 1;
            for (int i = 1; i <= 9; i++) if (cells[i] == 0) full = 0;
            if (win_line >= 0) begin
                m_over = 1;
                m_winner = mover + 1;
            end else if (full) begin
                m_over = 1;
                m_winner = 3;
            end else begin
                m_turn = 1 - m_turn;
            end
        end
        exp_done = (win_line >= 0) ? 3 + win_line : 10;

        @(negedge clk);
        move_valid = 1'b1;
        move_pos = 4'(p);
        @(posedge clk);
        #1 move_valid = 1'b0;
        chk("busy_e0", 32'(busy), 32'(!was_over));
        @(posedge clk);
        #1;
        chk("p1_en_e1", 32'(P1_en), 32'(exp1));
        chk("p2_en_e1", 32'(P2_en), 32'(exp2));
        chk("ill_e1", 32'(ill_move), 32'(!was_over && !legal));
        if (legal) begin
            chk("busy_e1", 32'(busy), 32'd1);
            done_k = 99;
            for (int k = 2; k <= 14; k++) begin
                @(posedge clk);
                #1;
                if (k == 2) chk("en_clear_e2", 32'({P1_en, P2_en}), 32'd0);
                if (!busy) begin
                    done_k = k;
                    break;
                end
            end
            chk("settle_edge", 32'(done_k), 32'(exp_done));
        end else if (!was_over) begin
            @(posedge clk);
            #1;
            chk("ill_e2", 32'(ill_move), 32'd0);
        end
        check_idle_outputs("after_move");
    endtask

    initial begin
        int q [$];
        int p;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p1", 32'(P1_en), 32'd0);
        chk("rst_p2", 32'(P2_en), 32'd0);
        chk("rst_ill", 32'(ill_move), 32'd0);
        check_idle_outputs("rst");
        @(negedge clk) reset = 1'b0;

        // Centre move by P1, then illegal attempts by P2
        do_move(5);
        do_move(5);
        do_move(0);
        do_move(12);

        // Row win for P1 on line 0, then a move after game over
        reset = 1'b1; model_reset(); @(negedge clk) reset = 1'b0;
        do_move(1); do_move(4); do_move(2); do_move(5); do_move(3);
        do_move(6);

        // Diagonal win for P2 on (3,5,7)
        reset = 1'b1; model_reset(); @(negedge clk) reset = 1'b0;
        do_move(1); do_move(3); do_move(4); do_move(5); do_move(8); do_move(7);

        // Full board with no line: draw
        reset = 1'b1; model_reset(); @(negedge clk) reset = 1'b0;
        do_move(1); do_move(2); do_move(3); do_move(5); do_move(4);
        do_move(6); do_move(8); do_move(7); do_move(9);

        // Reset during SCAN
        reset = 1'b1; model_reset(); @(negedge clk) reset = 1'b0;
        do_move(1);
        @(negedge clk);
        move_valid = 1'b1; move_pos = 4'd5;
        @(posedge clk);
        #1 move_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_scan_en", 32'({P1_en, P2_en}), 32'd0);
        check_idle_outputs("rst_scan");
        @(negedge clk) reset = 1'b0;

        // Reset during WRITE
        do_move(2);
        @(negedge clk);
        move_valid = 1'b1; move_pos = 4'd6;
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("write_p2", 32'(P2_en), 32'h020);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_write_en", 32'({P1_en, P2_en}), 32'd0);
        check_idle_outputs("rst_write");
        @(negedge clk) reset = 1'b0;
        do_move(6);

        // Random games, mostly sensible moves with some junk selections
        for (int g = 0; g < 8; g++) begin
            reset = 1'b1; model_reset(); @(negedge clk) reset = 1'b0;
            for (int m = 0; m < 20 && !m_over; m++) begin
                q.delete();
                for (int i = 1; i <= 9; i++) if (cells[i] == 0) q.push_back(i);
                if ($urandom_range(0, 3) == 0 || q.size() == 0) p = int'($urandom_range(0, 15));
                else p = q[$urandom_range(0, q.size() - 1)];
                do_move(p);
            end
            do_move(int'($urandom_range(1, 9)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
